// File: rtl/call_collector.sv
`default_nettype none
// ============================================================================
//  Module   : call_collector
//  Purpose  : Synchronise, debounce and latch floor call buttons, then issue
//             pending calls round-robin over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module call_collector #(
    parameter int FLOORS          = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] btn,
    input  logic              served_valid,
    input  logic [2:0]        served_floor,
    output logic              req_valid,
    output logic [2:0]        req_floor,
    input  logic              req_ready,
    output logic [FLOORS-1:0] pending
);

    localparam logic [2:0] c_deb_limit = 3'(DEBOUNCE_CYCLES);
    localparam logic [2:0] c_ptr_init  = 3'(FLOORS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    logic [FLOORS-1:0] r_sync1, r_sync2, r_deb, r_deb_q;
    logic [FLOORS-1:0] r_pend, r_iss, r_pending;
    logic [FLOORS-1:0] w_rise, w_elig, w_clr, w_iss_set, w_pend_nxt, w_iss_nxt;
    logic              w_found;
    logic [2:0]        w_winner;
    logic [3:0]        w_idx;

    state_t            r_state;
    logic              r_req_valid;
    logic [2:0]        r_req_floor;
    logic [2:0]        r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_deb_q   <= '0;
            r_pend    <= '0;
            r_iss     <= '0;
            r_pending <= '0;
        end else begin
            r_sync1   <= btn;
            r_sync2   <= r_sync1;
            r_deb_q   <= r_deb;
            r_pend    <= w_pend_nxt;
            r_iss     <= w_iss_nxt;
            r_pending <= w_pend_nxt | w_iss_nxt;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    for (genvar g = 0; g < FLOORS; g++) begin : g_debounce
        logic [2:0] r_cnt;
        logic       r_level;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (r_sync2[g] == r_level) begin
                r_cnt   <= '0;
            end else if (r_cnt + 3'd1 == c_deb_limit) begin
                r_level <= r_sync2[g];
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + 3'd1;
            end
        end

        assign r_deb[g] = r_level;
    end

    assign w_rise = r_deb & ~r_deb_q;
    assign w_elig = r_pend & ~r_iss;

    always_comb begin
        w_clr     = '0;
        w_iss_set = '0;
        if (served_valid && (int'(served_floor) < FLOORS))
            w_clr[served_floor] = 1'b1;
        if (r_state == ST_OFFER && req_ready)
            w_iss_set[r_req_floor] = 1'b1;
    end

    // Serve clear is applied last so it overrides a same-cycle press or issue.
    assign w_pend_nxt = (r_pend | (w_rise & ~r_iss)) & ~w_clr;
    assign w_iss_nxt  = (r_iss | w_iss_set) & ~w_clr;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= FLOORS; k++) begin
            w_idx = {1'b0, r_ptr} + 4'(k);
            if (w_idx >= 4'(FLOORS))
                w_idx = w_idx - 4'(FLOORS);
            if (!w_found && w_elig[w_idx[2:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_valid <= 1'b0;
            r_req_floor <= '0;
            r_ptr       <= c_ptr_init;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_req_floor <= w_winner;
                        r_req_valid <= 1'b1;
                        r_state     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (req_ready) begin
                        r_ptr       <= r_req_floor;
                        r_req_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (w_clr[r_req_floor]) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_req_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_valid = r_req_valid;
    assign req_floor = r_req_floor;
    assign pending   = r_pending;

endmodule
`default_nettype wire
